// File: rtl/axi_slave_responder.sv
// AXI3-style single-port slave: INCR bursts into a small register-file memory,
// per-byte write parity checking, independent write and read channel FSMs.
module axi_slave_responder #(
  parameter int ADDR_W    = 34,
  parameter int DATA_W    = 256,
  parameter int ID_W      = 6,
  parameter int MEM_DEPTH = 16
) (
  input  logic                AXI_ACLK,
  input  logic                AXI_ARESET_N,
  input  logic [ADDR_W-1:0]   AXI_AWADDR,
  input  logic [1:0]          AXI_AWBURST,
  input  logic [ID_W-1:0]     AXI_AWID,
  input  logic [3:0]          AXI_AWLEN,
  input  logic [2:0]          AXI_AWSIZE,
  input  logic                AXI_AWVALID,
  output logic                AXI_AWREADY,
  input  logic [DATA_W-1:0]   AXI_WDATA,
  input  logic [DATA_W/8-1:0] AXI_WSTRB,
  input  logic [DATA_W/8-1:0] AXI_WDATA_PARITY,
  input  logic                AXI_WLAST,
  input  logic                AXI_WVALID,
  output logic                AXI_WREADY,
  output logic [ID_W-1:0]     AXI_BID,
  output logic [1:0]          AXI_BRESP,
  output logic                AXI_BVALID,
  input  logic                AXI_BREADY,
  input  logic [ADDR_W-1:0]   AXI_ARADDR,
  input  logic [1:0]          AXI_ARBURST,
  input  logic [ID_W-1:0]     AXI_ARID,
  input  logic [3:0]          AXI_ARLEN,
  input  logic [2:0]          AXI_ARSIZE,
  input  logic                AXI_ARVALID,
  output logic                AXI_ARREADY,
  output logic [DATA_W-1:0]   AXI_RDATA,
  output logic [ID_W-1:0]     AXI_RID,
  output logic [1:0]          AXI_RRESP,
  output logic                AXI_RLAST,
  output logic                AXI_RVALID,
  input  logic                AXI_RREADY,
  output logic [15:0]         parity_err_count
);

  // Handshakes: a transfer happens on the rising clock edge where VALID and
  // READY are both 1; VALID-side payload holds stable until that edge.
  localparam int NB    = DATA_W / 8;
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  w_state_e          w_state_q, w_state_d;
  logic [IDX_W-1:0]  w_idx_q, w_idx_d;
  logic [ID_W-1:0]   w_id_q, w_id_d;
  logic [3:0]        w_len_q, w_len_d;
  logic [3:0]        w_beat_q, w_beat_d;
  logic              w_unsup_q, w_unsup_d;
  logic              w_err_q, w_err_d;
  logic              awready_q, awready_d;
  logic [15:0]       par_cnt_q, par_cnt_d;
  logic [DATA_W-1:0] mem_q [MEM_DEPTH];
  logic [DATA_W-1:0] mem_d [MEM_DEPTH];

  r_state_e          r_state_q, r_state_d;
  logic [IDX_W-1:0]  r_idx_q, r_idx_d;
  logic [3:0]        r_len_q, r_len_d;
  logic [3:0]        r_beat_q, r_beat_d;
  logic              r_unsup_q, r_unsup_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;

  logic [NB-1:0]     exp_par;
  logic              beat_bad;
  logic [IDX_W-1:0]  r_next_idx;
  logic [3:0]        r_next_beat;

  // Only strobed bytes take part in the parity verdict.
  always_comb begin
    exp_par = '0;
    for (int k = 0; k < NB; k++) begin
      exp_par[k] = ^AXI_WDATA[8*k +: 8];
    end
    beat_bad = |((exp_par ^ AXI_WDATA_PARITY) & AXI_WSTRB);
  end

  always_comb begin
    w_state_d = w_state_q;
    w_idx_d   = w_idx_q;
    w_id_d    = w_id_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_unsup_d = w_unsup_q;
    w_err_d   = w_err_q;
    par_cnt_d = par_cnt_q;
    mem_d     = mem_q;
    case (w_state_q)
      W_IDLE: begin
        if (AXI_AWVALID && awready_q) begin
          w_idx_d   = AXI_AWADDR[5 +: IDX_W];
          w_id_d    = AXI_AWID;
          w_len_d   = AXI_AWLEN;
          w_beat_d  = 4'd0;
          w_unsup_d = !(AXI_AWBURST == 2'b01 && AXI_AWSIZE == 3'd5);
          // An unsupported burst is answered with SLVERR from the start.
          w_err_d   = !(AXI_AWBURST == 2'b01 && AXI_AWSIZE == 3'd5);
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (AXI_WVALID) begin
          if (beat_bad) begin
            w_err_d = 1'b1;
            if (par_cnt_q != 16'hFFFF) par_cnt_d = par_cnt_q + 16'd1;
          end else if (!w_unsup_q) begin
            for (int k = 0; k < NB; k++) begin
              if (AXI_WSTRB[k]) mem_d[w_idx_q][8*k +: 8] = AXI_WDATA[8*k +: 8];
            end
          end
          if (AXI_WLAST != (w_beat_q == w_len_q)) w_err_d = 1'b1;
          w_idx_d  = w_idx_q + IDX_ONE;
          w_beat_d = w_beat_q + 4'd1;
          // Burst length is trusted from AWLEN, not from WLAST.
          if (w_beat_q == w_len_q) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (AXI_BREADY) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d == W_IDLE);
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      w_state_q <= W_IDLE;
      w_idx_q   <= '0;
      w_id_q    <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_unsup_q <= 1'b0;
      w_err_q   <= 1'b0;
      awready_q <= 1'b0;
      par_cnt_q <= '0;
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_idx_q   <= w_idx_d;
      w_id_q    <= w_id_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_unsup_q <= w_unsup_d;
      w_err_q   <= w_err_d;
      awready_q <= awready_d;
      par_cnt_q <= par_cnt_d;
      mem_q     <= mem_d;
    end
  end

  // Read data always comes from mem_q, so a same-cycle write is not visible.
  always_comb begin
    r_state_d   = r_state_q;
    r_idx_d     = r_idx_q;
    r_len_d     = r_len_q;
    r_beat_d    = r_beat_q;
    r_unsup_d   = r_unsup_q;
    rvalid_d    = rvalid_q;
    rdata_d     = rdata_q;
    rid_d       = rid_q;
    rresp_d     = rresp_q;
    rlast_d     = rlast_q;
    r_next_idx  = r_idx_q + IDX_ONE;
    r_next_beat = r_beat_q + 4'd1;
    case (r_state_q)
      R_IDLE: begin
        if (AXI_ARVALID && arready_q) begin
          r_idx_d   = AXI_ARADDR[5 +: IDX_W];
          r_len_d   = AXI_ARLEN;
          r_beat_d  = 4'd0;
          r_unsup_d = !(AXI_ARBURST == 2'b01 && AXI_ARSIZE == 3'd5);
          rdata_d   = r_unsup_d ? '0 : mem_q[r_idx_d];
          rresp_d   = r_unsup_d ? 2'b10 : 2'b00;
          rid_d     = AXI_ARID;
          rlast_d   = (AXI_ARLEN == 4'd0);
          rvalid_d  = 1'b1;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_idx_d  = r_next_idx;
            r_beat_d = r_next_beat;
            rdata_d  = r_unsup_q ? '0 : mem_q[r_next_idx];
            rlast_d  = (r_next_beat == r_len_q);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  always_ff @(posedge AXI_ACLK or negedge AXI_ARESET_N) begin
    if (!AXI_ARESET_N) begin
      r_state_q <= R_IDLE;
      r_idx_q   <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_unsup_q <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rid_q     <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_idx_q   <= r_idx_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_unsup_q <= r_unsup_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rid_q     <= rid_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  assign AXI_AWREADY      = awready_q;
  assign AXI_WREADY       = (w_state_q == W_DATA);
  assign AXI_BVALID       = (w_state_q == W_RESP);
  assign AXI_BID          = w_id_q;
  assign AXI_BRESP        = w_err_q ? 2'b10 : 2'b00;
  assign AXI_ARREADY      = arready_q;
  assign AXI_RVALID       = rvalid_q;
  assign AXI_RDATA        = rdata_q;
  assign AXI_RID          = rid_q;
  assign AXI_RRESP        = rresp_q;
  assign AXI_RLAST        = rlast_q;
  assign parity_err_count = par_cnt_q;

  // Address bits outside the word index alias and are deliberately ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{AXI_AWADDR[ADDR_W-1:5+IDX_W], AXI_AWADDR[4:0],
                              AXI_ARADDR[ADDR_W-1:5+IDX_W], AXI_ARADDR[4:0]};

endmodule

// File: doc/axi_slave_responder.md
Name: axi_slave_responder

Overview:
- Single-port AXI3-style slave that terminates one master channel of the 16-port AXI master control block. Used as the bench and loopback target for that master.
- Accepts INCR write and read bursts into a small internal register-file memory.
- Checks per-byte write-data parity and returns the B and R responses.
- Write and read paths run independently and concurrently.

Parameters:
- ADDR_W, 34, address width.
- DATA_W, 256, data width; bytes = DATA_W/8 = 32.
- ID_W, 6, transaction ID width.
- MEM_DEPTH, 16, number of DATA_W words; power of two.

Ports:
AXI_ACLK  in  1  clock
AXI_ARESET_N  in  1  async active-low reset
AXI_AWADDR  in  ADDR_W  write address
AXI_AWBURST  in  2  write burst type
AXI_AWID  in  ID_W  write ID
AXI_AWLEN  in  4  beats-1
AXI_AWSIZE  in  3  beat size
AXI_AWVALID  in  1  AW valid
AXI_AWREADY  out  1  AW ready
AXI_WDATA  in  DATA_W  write data
AXI_WSTRB  in  DATA_W/8  byte enables
AXI_WDATA_PARITY  in  DATA_W/8  per-byte XOR parity
AXI_WLAST  in  1  last write beat
AXI_WVALID  in  1  W valid
AXI_WREADY  out  1  W ready
AXI_BID  out  ID_W  response ID
AXI_BRESP  out  2  write response
AXI_BVALID  out  1  B valid
AXI_BREADY  in  1  B ready
AXI_ARADDR  in  ADDR_W  read address
AXI_ARBURST  in  2  read burst type
AXI_ARID  in  ID_W  read ID
AXI_ARLEN  in  4  beats-1
AXI_ARSIZE  in  3  beat size
AXI_ARVALID  in  1  AR valid
AXI_ARREADY  out  1  AR ready
AXI_RDATA  out  DATA_W  read data
AXI_RID  out  ID_W  read ID
AXI_RRESP  out  2  read response
AXI_RLAST  out  1  last read beat
AXI_RVALID  out  1  R valid
AXI_RREADY  in  1  R ready
parity_err_count  out  16  saturating count of beats with a parity error

Behaviour:
- Clocking and reset:
  - One clock, AXI_ACLK.
  - Reset is asynchronous, active-low on AXI_ARESET_N.
  - On reset assertion every output goes to 0 immediately, both FSMs return to IDLE, memory clears to 0 and parity_err_count clears to 0.
  - Reset mid-burst abandons the burst; no B or R response is issued for it.
  - AWREADY and ARREADY are registered. They are 0 during reset and 1 from the first clock edge after reset release.
- Address mapping:
  - word index = ADDR[5+log2(MEM_DEPTH)-1:5]; upper address bits alias.
  - Index increments by 1 per beat and wraps modulo MEM_DEPTH.
- Burst legality: a burst is supported only when BURST=2'b01 and SIZE=3'd5. Any other combination is unsupported.
- Write FSM, states W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: AWREADY=1. On AWVALID&&AWREADY latch index, ID, LEN, and the unsupported flag; go to W_DATA.
  - W_DATA: WREADY=1.
    - Per accepted beat, expected parity bit k = ^WDATA[8k+7:8k].
    - If any strobed byte mismatches: set the sticky SLVERR flag, write no byte of that beat, and increment parity_err_count (saturates at 16'hFFFF).
    - Otherwise write the strobed bytes, unless the burst is unsupported.
  - WLAST: WLAST must equal (beat == LEN). A mismatch sets SLVERR. The burst always ends after LEN+1 beats, counted internally.
  - W_RESP: BVALID=1, BID = latched ID, BRESP = 2'b10 if the SLVERR flag is set, else 2'b00. BVALID, BID and BRESP hold stable until BREADY; then go to W_IDLE.
- Read FSM, states R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ARREADY=1. The AR handshake loads RDATA/RID/RRESP/RLAST registers for beat 0. RVALID rises the next cycle (latency 1).
  - R_DATA: RVALID=1 and the outputs hold until RREADY. Each RVALID&&RREADY loads the next beat. On the beat with RLAST=1, go to R_IDLE and deassert RVALID.
  - RLAST=1 only on beat ARLEN.
  - Unsupported read: RDATA=0 and RRESP=2'b10 on every beat, with LEN+1 beats still returned.
- Same-cycle read load and memory write to the same word: the read returns pre-write data.
- AW and AR handshakes in the same cycle are both accepted.

Test Plan:
- Write burst AWADDR=34'h40, ID=5, LEN=15, beat n data = {8{32'hA5A50000+n}}, correct parity -> 16 WREADY beats, then BVALID with BID=5, BRESP=00. Read back ARADDR=34'h40, ARID=7, LEN=15 -> 16 beats match, RID=7, RRESP=00, RLAST on beat 15 only.
- Same write with byte 0 parity of beat 3 flipped -> BRESP=10, parity_err_count=1. Readback: word 5 (beat 3) = 0, other words written.
- Single beat, WSTRB=32'h0000000F, data all 1s to a zeroed word -> readback 256'h...0000FFFFFFFF.
- Wrap: AWADDR word 14, LEN=3 -> words 14,15,0,1 written. Read word 0 LEN=0 returns beat 2 data.
- AWBURST=2'b10 -> BRESP=10, memory unchanged. ARSIZE=3'd4, LEN=2 -> 3 beats, RDATA=0, RRESP=10.
- Backpressure and reset:
  - Hold BREADY=0 for 10 cycles -> BVALID/BID/BRESP stable and AWREADY=0 throughout.
  - Hold RREADY=0 -> RDATA stable.
  - Assert reset during beat 2 of a read -> RVALID=0 immediately; after release, ARREADY=1 and parity_err_count=0.
